// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the round-robin UART TX arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = 8;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;

endpackage

// File: rtl/uart_port_arbiter_if.sv
// Requester-side byte handshake plus the shared DCE pins of the TX arbiter.
interface uart_port_arbiter_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DBR_W     = 32
);
    localparam int unsigned ID_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]   req_valid;
    logic [8*NUM_PORTS-1:0] req_data;
    logic [NUM_PORTS-1:0]   req_ready;
    logic                   cts;
    logic [DBR_W-1:0]       dbr;
    logic                   txd;
    logic [ID_W-1:0]        grant_id;
    logic                   busy;
    logic                   frame_done;

    modport master (
        output req_valid, req_data, cts, dbr,
        input  req_ready, txd, grant_id, busy, frame_done
    );

    modport slave (
        input  req_valid, req_data, cts, dbr,
        output req_ready, txd, grant_id, busy, frame_done
    );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last winner.
module uart_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    logic [$clog2(N)-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = $clog2(N)'((32'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/uart_port_arbiter.sv
// Shares one 8N1 TX line among NUM_PORTS byte requesters, one character per grant,
// gated by CTS and paced by a runtime clocks-per-bit divisor.
module uart_port_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DBR_W     = 32
) (
    input logic                 clock,
    input logic                 reset_n,
    uart_port_arbiter_if.slave  bus
);

    localparam int unsigned ID_W = $clog2(NUM_PORTS);

    state_e               state_q, state_d;
    logic [DBR_W-1:0]     baud_q, baud_d, div_q, div_d, div_new;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d, win_byte;
    logic                 txd_q, txd_d;
    logic [ID_W-1:0]      gid_q, gid_d, ptr_q, ptr_d, win_idx;
    logic [NUM_PORTS-1:0] win_grant, ready;
    logic                 win_valid, done;

    uart_rr_arbiter #(.N(NUM_PORTS)) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (win_grant),
        .idx   (win_idx),
        .valid (win_valid)
    );

    always_comb begin
        win_byte = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (win_grant[i]) win_byte = bus.req_data[8*i +: 8];
        end
    end

    // A zero divisor would never let the baud counter reach a bit boundary.
    assign div_new = (bus.dbr == '0) ? DBR_W'(1) : bus.dbr;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        ready   = '0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                txd_d = STOP_BIT;
                if (bus.cts && win_valid) begin
                    ready   = win_grant;
                    shift_d = win_byte;
                    div_d   = div_new;
                    baud_d  = div_new - DBR_W'(1);
                    bit_d   = '0;
                    gid_d   = win_idx;
                    ptr_d   = win_idx;
                    txd_d   = START_BIT;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    baud_d  = div_q - DBR_W'(1);
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - DBR_W'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = div_q - DBR_W'(1);
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        txd_d   = STOP_BIT;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q - DBR_W'(1);
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q - DBR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            div_q   <= DBR_W'(1);
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= STOP_BIT;
            gid_q   <= '0;
            ptr_q   <= ID_W'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.txd        = txd_q;
    assign bus.grant_id   = gid_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = done;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Randomised bench for uart_port_arbiter against a frame-level reference model.
module tb_uart_port_arbiter;

    localparam int NP  = 4;
    localparam int DW  = 32;
    localparam int IDW = $clog2(NP);

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   ptr_m;

    always #5 clock = ~clock;

    uart_port_arbiter_if #(.NUM_PORTS(NP), .DBR_W(DW)) bus ();

    uart_port_arbiter #(.NUM_PORTS(NP), .DBR_W(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Next owner: first requesting port after the last winner, wrapping around.
    function automatic int rr_pick(logic [NP-1:0] v, int ptr);
        for (int k = 1; k <= NP; k++) begin
            if (v[(ptr + k) % NP]) return (ptr + k) % NP;
        end
        return -1;
    endfunction

    // Line level at clock j of a frame: slot 0 start, 1..8 data LSB first, 9 stop.
    function automatic logic frame_bit(logic [7:0] b, int j, int d);
        int s;
        s = j / d;
        if (s == 0) return 1'b0;
        if (s >= 9) return 1'b1;
        return b[s-1];
    endfunction

    function automatic logic [NP-1:0] onehot(int w);
        logic [NP-1:0] r;
        r    = '0;
        r[w] = 1'b1;
        return r;
    endfunction

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0 ||
            bus.grant_id !== '0 || bus.req_ready !== '0) begin
            errors++;
            $display("FAIL reset_state: txd=%b busy=%b done=%b gid=%0d rdy=%b want 1 0 0 0 0000",
                     bus.txd, bus.busy, bus.frame_done, bus.grant_id, bus.req_ready);
        end
        reset_n = 1'b1;
        ptr_m   = NP - 1;
        @(negedge clock);
        checks++;
        if (bus.txd !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: txd=%b busy=%b want 1 0", bus.txd, bus.busy);
        end
    endtask

    task automatic test_round_robin;
        int         w;
        logic [7:0] b;
        bus.dbr = 2;
        bus.cts = 1'b1;
        for (int p = 0; p < NP; p++) bus.req_data[8*p +: 8] = 8'($urandom);
        bus.req_valid = '1;
        for (int f = 0; f < 5; f++) begin
            #1;
            w = rr_pick(bus.req_valid, ptr_m);
            b = bus.req_data[8*w +: 8];
            checks++;
            if (bus.req_ready !== onehot(w) || w != (f % NP)) begin
                errors++;
                $display("FAIL rr_grant f%0d: rdy=%b want %b (port %0d)",
                         f, bus.req_ready, onehot(f % NP), f % NP);
            end
            ptr_m = w;
            @(posedge clock);
            #1;
            bus.req_data[8*w +: 8] = 8'($urandom);
            for (int j = 0; j < 20; j++) begin
                @(negedge clock);
                checks++;
                if (bus.txd !== frame_bit(b, j, 2) || bus.busy !== 1'b1 ||
                    bus.frame_done !== (j == 19) || bus.req_ready !== '0 ||
                    bus.grant_id !== IDW'(w)) begin
                    errors++;
                    $display("FAIL rr_frame f%0d c%0d: txd=%b done=%b rdy=%b gid=%0d want txd=%b done=%b rdy=0 gid=%0d",
                             f, j, bus.txd, bus.frame_done, bus.req_ready, bus.grant_id,
                             frame_bit(b, j, 2), (j == 19), w);
                end
            end
            @(negedge clock);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_single;
        logic [7:0] b;
        b                  = 8'hA5;
        bus.dbr            = 4;
        bus.req_data[23:16] = b;
        bus.req_valid      = 4'b0100;
        #1;
        ptr_m = rr_pick(bus.req_valid, ptr_m);
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: rdy=%b want 0100", bus.req_ready);
        end
        @(posedge clock);
        #1;
        bus.req_valid = '0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clock);
            checks++;
            if (bus.txd !== frame_bit(b, j, 4) || bus.busy !== 1'b1 ||
                bus.frame_done !== (j == 39) || bus.grant_id !== IDW'(2) ||
                bus.req_ready !== '0) begin
                errors++;
                $display("FAIL single_frame c%0d: txd=%b done=%b gid=%0d want txd=%b done=%b gid=2",
                         j, bus.txd, bus.frame_done, bus.grant_id, frame_bit(b, j, 4), (j == 39));
            end
        end
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || bus.txd !== 1'b1) begin
            errors++;
            $display("FAIL single_idle: busy=%b txd=%b want 0 1", bus.busy, bus.txd);
        end
    endtask

    task automatic test_cts;
        logic [7:0] b;
        b                  = 8'($urandom);
        bus.cts            = 1'b0;
        bus.dbr            = 3;
        bus.req_data[15:8] = b;
        bus.req_valid      = 4'b0010;
        for (int i = 0; i < 50; i++) begin
            #1;
            checks++;
            if (bus.req_ready !== '0 || bus.txd !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL cts_hold c%0d: rdy=%b txd=%b busy=%b want 0000 1 0",
                         i, bus.req_ready, bus.txd, bus.busy);
            end
            @(negedge clock);
        end
        bus.cts = 1'b1;
        #1;
        ptr_m = rr_pick(bus.req_valid, ptr_m);
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL cts_ready: rdy=%b want 0010", bus.req_ready);
        end
        @(posedge clock);
        #1;
        bus.req_valid = '0;
        for (int j = 0; j < 30; j++) begin
            if (j == 5) bus.cts = 1'b0;
            @(negedge clock);
            checks++;
            if (bus.txd !== frame_bit(b, j, 3) || bus.busy !== 1'b1 ||
                bus.frame_done !== (j == 29)) begin
                errors++;
                $display("FAIL cts_frame c%0d: txd=%b done=%b want txd=%b done=%b",
                         j, bus.txd, bus.frame_done, frame_bit(b, j, 3), (j == 29));
            end
        end
        @(negedge clock);
        bus.cts = 1'b1;
    endtask

    task automatic test_dbr_zero;
        bus.dbr             = 0;
        bus.req_data[31:24] = 8'h00;
        bus.req_valid       = 4'b1000;
        #1;
        ptr_m = rr_pick(bus.req_valid, ptr_m);
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL dbr0_ready: rdy=%b want 1000", bus.req_ready);
        end
        @(posedge clock);
        #1;
        bus.req_valid = '0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            checks++;
            if (bus.txd !== (j == 9) || bus.frame_done !== (j == 9) || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL dbr0_frame c%0d: txd=%b done=%b want txd=%b done=%b",
                         j, bus.txd, bus.frame_done, (j == 9), (j == 9));
            end
        end
        @(negedge clock);
    endtask

    task automatic test_dbr_change;
        logic [7:0] b;
        int         d;
        bus.dbr           = 4;
        bus.req_data[7:0] = 8'($urandom);
        bus.req_valid     = 4'b0001;
        for (int f = 0; f < 2; f++) begin
            #1;
            d = (f == 0) ? 4 : 6;
            b = bus.req_data[7:0];
            ptr_m = rr_pick(bus.req_valid, ptr_m);
            checks++;
            if (bus.req_ready !== 4'b0001) begin
                errors++;
                $display("FAIL dbrchg_ready f%0d: rdy=%b want 0001", f, bus.req_ready);
            end
            @(posedge clock);
            #1;
            bus.dbr           = 6;
            bus.req_data[7:0] = 8'($urandom);
            if (f == 1) bus.req_valid = '0;
            for (int j = 0; j < 10 * d; j++) begin
                @(negedge clock);
                checks++;
                if (bus.txd !== frame_bit(b, j, d) || bus.busy !== 1'b1 ||
                    bus.frame_done !== (j == 10 * d - 1)) begin
                    errors++;
                    $display("FAIL dbrchg_frame f%0d c%0d: txd=%b done=%b want txd=%b done=%b",
                             f, j, bus.txd, bus.frame_done, frame_bit(b, j, d), (j == 10 * d - 1));
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_random;
        int            w, d;
        logic [7:0]    b;
        for (int f = 0; f < 8; f++) begin
            bus.req_valid = NP'($urandom_range(1, (1 << NP) - 1));
            for (int p = 0; p < NP; p++) bus.req_data[8*p +: 8] = 8'($urandom);
            bus.dbr = DW'($urandom_range(0, 5));
            bus.cts = 1'b1;
            #1;
            w = rr_pick(bus.req_valid, ptr_m);
            b = bus.req_data[8*w +: 8];
            d = (bus.dbr == 0) ? 1 : int'(bus.dbr);
            checks++;
            if (bus.req_ready !== onehot(w)) begin
                errors++;
                $display("FAIL rand_ready f%0d: rdy=%b want %b", f, bus.req_ready, onehot(w));
            end
            ptr_m = w;
            @(posedge clock);
            #1;
            bus.req_valid = NP'($urandom);
            bus.dbr       = DW'($urandom_range(0, 15));
            bus.cts       = 1'($urandom);
            for (int j = 0; j < 10 * d; j++) begin
                @(negedge clock);
                checks++;
                if (bus.txd !== frame_bit(b, j, d) || bus.busy !== 1'b1 ||
                    bus.frame_done !== (j == 10 * d - 1) || bus.grant_id !== IDW'(w)) begin
                    errors++;
                    $display("FAIL rand_frame f%0d c%0d: txd=%b done=%b gid=%0d want txd=%b done=%b gid=%0d",
                             f, j, bus.txd, bus.frame_done, bus.grant_id,
                             frame_bit(b, j, d), (j == 10 * d - 1), w);
                end
            end
            @(negedge clock);
        end
        bus.req_valid = '0;
        bus.cts       = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        int         w;
        bus.dbr            = 8;
        bus.req_data[15:8] = 8'($urandom);
        bus.req_valid      = 4'b0010;
        #1;
        @(posedge clock);
        #1;
        bus.req_valid = '0;
        repeat (30) @(negedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: txd=%b busy=%b done=%b want 1 0 0",
                     bus.txd, bus.busy, bus.frame_done);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        ptr_m   = NP - 1;
        bus.req_data[7:0]   = 8'($urandom);
        bus.req_data[31:24] = 8'($urandom);
        bus.req_valid       = 4'b1001;
        #1;
        w = rr_pick(bus.req_valid, ptr_m);
        b = bus.req_data[8*w +: 8];
        checks++;
        if (bus.req_ready !== 4'b0001 || w != 0) begin
            errors++;
            $display("FAIL reset_prio: rdy=%b want 0001", bus.req_ready);
        end
        @(posedge clock);
        #1;
        bus.req_valid = '0;
        for (int j = 0; j < 80; j++) begin
            @(negedge clock);
            checks++;
            if (bus.txd !== frame_bit(b, j, 8) || bus.frame_done !== (j == 79) ||
                bus.grant_id !== IDW'(0)) begin
                errors++;
                $display("FAIL reset_frame c%0d: txd=%b done=%b gid=%0d want txd=%b done=%b gid=0",
                         j, bus.txd, bus.frame_done, bus.grant_id, frame_bit(b, j, 8), (j == 79));
            end
        end
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.cts       = 1'b1;
        bus.dbr       = 4;
        reset_n       = 1'b0;
        test_reset;
        test_round_robin;
        test_single;
        test_cts;
        test_dbr_zero;
        test_dbr_change;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
